// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_skid_stage pipeline register.
package pipe_pkg;

   localparam int unsigned PC_W_DEF    = 32;
   localparam int unsigned INSTR_W_DEF = 32;

   // addi $t0,$zero,0 : bubble presented whenever the stage holds no beat
   localparam logic [31:0] NOP_INSTR = 32'h20080000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [PC_W_DEF-1:0]    pc;
      logic [INSTR_W_DEF-1:0] instr;
   } payload_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage entry of the skid stage: valid bit plus payload, with load and clear.
module pipe_entry_reg #(
   parameter int unsigned W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Clear only drops the valid bit; payload changes only when loaded.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         if (clear_i) begin
            valid_q <= 1'b0;
         end else if (load_i) begin
            valid_q <= 1'b1;
         end
         if (load_i) begin
            data_q <= data_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional PIPE_STAGE_STATS_EN adds stall_cycles / flush_count counters.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned        PC_W    = 32,
   parameter int unsigned        INSTR_W = 32,
   parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
   input  logic               clock,
   input  logic               reset,
`ifdef PIPE_STAGE_STATS_EN
   output logic [31:0]        stall_cycles,
   output logic [15:0]        flush_count,
`endif
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr
);

   localparam int unsigned ENT_W = PC_W + INSTR_W;

   state_e             state_q, state_d;
   logic               in_ready_q;
   logic               accept, leave;
   logic               m_load, m_clr, m_from_s, s_load, s_clr;
   logic               m_valid, s_valid;
   logic [ENT_W-1:0]   m_data, s_data, m_din, in_data;

   assign in_data = {in_pc, in_instr};
   assign m_din   = m_from_s ? s_data : in_data;
   assign accept  = in_valid & in_ready_q;
   assign leave   = m_valid & out_ready & ~stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
      end
   end

   // Next state and entry load/clear strobes; flush overrides everything.
   always_comb begin
      state_d  = state_q;
      m_load   = 1'b0;
      m_clr    = 1'b0;
      m_from_s = 1'b0;
      s_load   = 1'b0;
      s_clr    = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
         m_clr   = 1'b1;
         s_clr   = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  m_load  = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && leave) begin
                  m_load = 1'b1;
               end else if (accept) begin
                  state_d = ST_TWO;
                  s_load  = 1'b1;
               end else if (leave) begin
                  state_d = ST_EMPTY;
                  m_clr   = 1'b1;
               end
            end
            ST_TWO: begin
               if (leave) begin
                  state_d  = ST_ONE;
                  m_load   = 1'b1;
                  m_from_s = 1'b1;
                  s_clr    = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               m_clr   = 1'b1;
               s_clr   = 1'b1;
            end
         endcase
      end
   end

   pipe_entry_reg #(.W(ENT_W)) u_main (
      .clock   (clock),
      .reset   (reset),
      .load_i  (m_load),
      .clear_i (m_clr),
      .data_i  (m_din),
      .valid_o (m_valid),
      .data_o  (m_data)
   );

   pipe_entry_reg #(.W(ENT_W)) u_skid (
      .clock   (clock),
      .reset   (reset),
      .load_i  (s_load),
      .clear_i (s_clr),
      .data_i  (in_data),
      .valid_o (s_valid),
      .data_o  (s_data)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = m_valid;
   assign out_pc    = m_data[ENT_W-1 -: PC_W];
   assign out_instr = m_valid ? m_data[INSTR_W-1:0] : NOP;

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   // Free-running event counters, wrapping at full scale.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (m_valid && stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (flush) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based reference model plus directed literal checks.
module tb_pipe_skid_stage;
   import pipe_pkg::*;

   localparam logic [31:0] NOPV = 32'h20080000;
   localparam logic [31:0] XORK = 32'hA5A50000;

   logic        clock = 1'b0;
   logic        reset, in_valid, in_ready, stall, flush, out_valid, out_ready;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   always #5 clock = ~clock;

   pipe_skid_stage dut (
      .clock     (clock),
      .reset     (reset),
`ifdef PIPE_STAGE_STATS_EN
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr)
   );

   // Reference model: the stage is a FIFO of at most two beats, head is what is presented.
   payload_t    q[$];
   logic [31:0] m_stall = '0;
   logic [15:0] m_flush = '0;

   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            q.delete();
            m_stall = '0;
            m_flush = '0;
         end else begin
            if (q.size() > 0 && stall) m_stall = m_stall + 32'd1;
            if (flush) begin
               m_flush = m_flush + 16'd1;
               q.delete();
            end else begin
               automatic bit lv  = (q.size() > 0) && out_ready && !stall;
               automatic bit acc = in_valid && (q.size() < 2);
               automatic payload_t b;
               b.pc    = in_pc;
               b.instr = in_instr;
               if (lv) void'(q.pop_front());
               if (acc) q.push_back(b);
            end
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   logic        lit_en = 1'b0, lit_v, lit_rdy, lit_cpc;
   logic [31:0] lit_pc;
   logic        lit_st_en = 1'b0;
   logic [31:0] lit_st;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Compare process: model every cycle, plus any literal expectation posted by the stimulus.
   initial begin
      forever begin
         @(negedge clock);
         chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("out_instr", out_instr, (q.size() > 0) ? q[0].instr : NOPV);
         if (q.size() > 0) chk("out_pc", out_pc, q[0].pc);
`ifdef PIPE_STAGE_STATS_EN
         chk("stall_cycles", stall_cycles, m_stall);
         chk("flush_count", 32'(flush_count), 32'(m_flush));
         if (lit_st_en) chk("lit_stall_cycles", stall_cycles, lit_st);
`endif
         if (lit_en) begin
            chk("lit_valid", 32'(out_valid), 32'(lit_v));
            chk("lit_ready", 32'(in_ready), 32'(lit_rdy));
            chk("lit_instr", out_instr, lit_v ? (lit_pc ^ XORK) : NOPV);
            if (lit_cpc) chk("lit_pc", out_pc, lit_pc);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
      lit_en    = 1'b0;
      lit_st_en = 1'b0;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_instr = pc ^ XORK;
   endtask

   task automatic expect_lit(input logic v, input logic [31:0] pc, input logic rdy, input logic cpc);
      lit_en  = 1'b1;
      lit_v   = v;
      lit_pc  = pc;
      lit_rdy = rdy;
      lit_cpc = cpc;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'd0);
      step(); step();
      reset = 1'b0;
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b1);

      // Streaming at full rate
      drive(1'b1, 32'd4);  step(); expect_lit(1'b1, 32'd4, 1'b1, 1'b1);
      drive(1'b1, 32'd8);  step(); expect_lit(1'b1, 32'd8, 1'b1, 1'b1);
      drive(1'b1, 32'd12); step(); expect_lit(1'b1, 32'd12, 1'b1, 1'b1);
      drive(1'b0, 32'd0);  step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);

      // Back-pressure fills the skid entry, then drains back-to-back
      out_ready = 1'b0;
      drive(1'b1, 32'd4); step(); expect_lit(1'b1, 32'd4, 1'b1, 1'b1);
      drive(1'b1, 32'd8); step(); expect_lit(1'b1, 32'd4, 1'b0, 1'b1);
      drive(1'b0, 32'd0); out_ready = 1'b1;
      step(); expect_lit(1'b1, 32'd8, 1'b1, 1'b1);
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);

      // Flush while two beats are held, with an offered beat
      out_ready = 1'b0;
      drive(1'b1, 32'd24); step(); expect_lit(1'b1, 32'd24, 1'b1, 1'b1);
      drive(1'b1, 32'd28); step(); expect_lit(1'b1, 32'd24, 1'b0, 1'b1);
      flush = 1'b1; drive(1'b1, 32'd16);
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);
      flush = 1'b0; drive(1'b0, 32'd0); out_ready = 1'b1;
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);

      // Flush discards a beat accepted in the same cycle
      out_ready = 1'b0;
      drive(1'b1, 32'd36); step(); expect_lit(1'b1, 32'd36, 1'b1, 1'b1);
      flush = 1'b1; drive(1'b1, 32'd16);
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);
      flush = 1'b0; drive(1'b0, 32'd0); out_ready = 1'b1;
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);

      // Stall holds the beat even though downstream is ready
      reset = 1'b1; step();
      reset = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'd20); step(); expect_lit(1'b1, 32'd20, 1'b1, 1'b1);
      drive(1'b0, 32'd0); stall = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); expect_lit(1'b1, 32'd20, 1'b1, 1'b1);
      end
      lit_st_en = 1'b1; lit_st = 32'd5;
      stall = 1'b0;
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);

      // Reset while in TWO drops both beats
      out_ready = 1'b0;
      drive(1'b1, 32'd40); step();
      drive(1'b1, 32'd44); step(); expect_lit(1'b1, 32'd40, 1'b0, 1'b1);
      reset = 1'b1; drive(1'b0, 32'd0);
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b1);
      reset = 1'b0; out_ready = 1'b1;
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);
      step(); expect_lit(1'b0, 32'd0, 1'b1, 1'b0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         stall     = ($urandom_range(0, 7) == 0);
         flush     = ($urandom_range(0, 19) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         in_pc     = $urandom;
         in_instr  = $urandom;
         step();
      end

      reset = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
      @(negedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
